// File: rtl/vrf_pkg.sv
// Shared definitions for the vector register file slice.
//   LANE_W / LANES : default lane width and lane count
//   lane_t / vec_t : one lane / one packed vector at the default geometry
//   addr_t         : 4-bit register address, REG_PC (15) selects the r15 input
//   ld_state_t     : lane-serial load engine states
//   reg_onehot()   : scoreboard bit for a register address (0 for REG_PC)
package vrf_pkg;

  localparam int LANE_W   = 18;
  localparam int LANES    = 3;
  localparam int NUM_REGS = 15;

  typedef logic [LANE_W-1:0]             lane_t;
  typedef logic [LANES-1:0][LANE_W-1:0]  vec_t;
  typedef logic [3:0]                    addr_t;

  localparam addr_t REG_PC = 4'd15;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input addr_t a);
    reg_onehot = '0;
    if (a != REG_PC) reg_onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_vector_stream_if.sv
// Bus bundle for the vector register file.
//   Port-3 write : WriteEnable, WriteAddr, WriteMask, WriteData
//   Reads        : ra1/ra2 -> rd1/rd2, r15 supplies the PC+8 value
//   Load stream  : ld_start, ld_addr, s_valid, s_data -> s_ready, ld_busy,
//                  ld_done, busy
// master = the pipeline driving the register file, slave = the register file.
interface regfile_vector_stream_if #(
  parameter int N = 18,
  parameter int V = 3
) ();

  logic             WriteEnable;
  logic [3:0]       WriteAddr;
  logic [V-1:0]     WriteMask;
  logic [V*N-1:0]   WriteData;
  logic [3:0]       ra1;
  logic [3:0]       ra2;
  logic [N-1:0]     r15;
  logic [V*N-1:0]   rd1;
  logic [V*N-1:0]   rd2;
  logic             ld_start;
  logic [3:0]       ld_addr;
  logic             s_valid;
  logic [N-1:0]     s_data;
  logic             s_ready;
  logic             ld_busy;
  logic             ld_done;
  logic [14:0]      busy;

  modport master (
    output WriteEnable, WriteAddr, WriteMask, WriteData,
    output ra1, ra2, r15,
    input  rd1, rd2,
    output ld_start, ld_addr, s_valid, s_data,
    input  s_ready, ld_busy, ld_done, busy
  );

  modport slave (
    input  WriteEnable, WriteAddr, WriteMask, WriteData,
    input  ra1, ra2, r15,
    output rd1, rd2,
    input  ld_start, ld_addr, s_valid, s_data,
    output s_ready, ld_busy, ld_done, busy
  );

endinterface

// File: rtl/vrf_stream_ctrl.sv
// Lane-serial load engine: accepts one stream beat per lane for a latched
// target register, then pulses ld_done for one cycle.
//   clk, reset          : clock, async active-high reset
//   ld_start, ld_addr   : start request and destination register
//   s_valid / s_ready   : stream handshake (s_ready high only in LOAD)
//   ld_busy, ld_done    : load in progress / one-cycle completion pulse
//   busy                : one-hot of the target during LOAD and DONE
//   lane_we, lane_idx,
//   lane_reg            : lane write command to the storage array
module vrf_stream_ctrl
  import vrf_pkg::*;
#(
  parameter  int V  = LANES,
  localparam int CW = (V > 1) ? $clog2(V) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_start,
  input  addr_t                ld_addr,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 ld_busy,
  output logic                 ld_done,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 lane_we,
  output logic [CW-1:0]        lane_idx,
  output addr_t                lane_reg
);

  ld_state_t      state;
  logic [CW-1:0]  cnt;
  addr_t          target;

  // Outputs are registered alongside the state so they change only on edges
  // (and on reset), never as a glitchy decode of the state vector.
  // NOTE: all state here uses <= so every register samples pre-edge values;
  // a blocking assignment would let later statements see the new state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      target  <= '0;
      s_ready <= 1'b0;
      ld_busy <= 1'b0;
      ld_done <= 1'b0;
      busy    <= '0;
    end else begin
      ld_done <= 1'b0;
      unique case (state)
        IDLE: begin
          // A start aimed at the PC alias has no storage behind it.
          if (ld_start && ld_addr != REG_PC) begin
            state   <= LOAD;
            target  <= ld_addr;
            cnt     <= '0;
            busy    <= reg_onehot(ld_addr);
            s_ready <= 1'b1;
            ld_busy <= 1'b1;
          end
        end
        LOAD: begin
          if (s_valid) begin
            if (cnt == CW'(V - 1)) begin
              state   <= DONE;
              cnt     <= '0;
              s_ready <= 1'b0;
              ld_busy <= 1'b0;
              ld_done <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // s_ready is high exactly in LOAD, so it doubles as the state qualifier.
  assign lane_we  = s_ready && s_valid;
  assign lane_idx = cnt;
  assign lane_reg = target;

endmodule

// File: rtl/regfile_vector_stream.sv
// Vector register file: 15 registers of V lanes x N bits, two combinational
// read ports, one lane-masked write port and a lane-serial stream loader.
// Address 15 reads r15 broadcast to every lane and is never written.
//   clk, reset : clock, async active-high reset (clears all registers)
//   bus        : regfile_vector_stream_if slave (write, read, load stream)
module regfile_vector_stream
  import vrf_pkg::*;
#(
  parameter int N = LANE_W,
  parameter int V = LANES
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_vector_stream_if.slave   bus
);

  localparam int CW = (V > 1) ? $clog2(V) : 1;

  logic [V-1:0][N-1:0]  regs [NUM_REGS];
  logic [V-1:0][N-1:0]  wdata;

  logic                 lane_we;
  logic [CW-1:0]        lane_idx;
  addr_t                lane_reg;

  assign wdata = bus.WriteData;

  vrf_stream_ctrl #(.V(V)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .ld_start (bus.ld_start),
    .ld_addr  (bus.ld_addr),
    .s_valid  (bus.s_valid),
    .s_ready  (bus.s_ready),
    .ld_busy  (bus.ld_busy),
    .ld_done  (bus.ld_done),
    .busy     (bus.busy),
    .lane_we  (lane_we),
    .lane_idx (lane_idx),
    .lane_reg (lane_reg)
  );

  // NOTE: the array is reset on purpose: an aborted load must not leave
  // partial lanes behind, which keeps it out of RAM macros by design.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      if (bus.WriteEnable && bus.WriteAddr != REG_PC) begin
        for (int i = 0; i < V; i++) begin
          if (bus.WriteMask[i]) regs[bus.WriteAddr][i] <= wdata[i];
        end
      end
      // Placed after the port-3 write: on a same-lane collision the last
      // scheduled update takes effect, so the stream beat wins.
      if (lane_we) regs[lane_reg][lane_idx] <= bus.s_data;
    end
  end

  // Reads see pre-edge contents; there is no write-to-read bypass.
  assign bus.rd1 = (bus.ra1 == REG_PC) ? {V{bus.r15}} : regs[bus.ra1];
  assign bus.rd2 = (bus.ra2 == REG_PC) ? {V{bus.r15}} : regs[bus.ra2];

endmodule

// File: tb/tb_regfile_vector_stream.sv
// Self-checking bench for regfile_vector_stream (N=18, V=3): directed
// scenarios with literal expectations, then randomized traffic, all compared
// every cycle against a transaction-level model of the register file.
module tb_regfile_vector_stream;

  localparam int N = 18;
  localparam int V = 3;
  localparam int W = V * N;

  logic clk = 1'b0;
  logic reset;

  regfile_vector_stream_if #(.N(N), .V(V)) bus ();

  regfile_vector_stream #(.N(N), .V(V)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // ---------------- behavioural model ----------------
  logic [N-1:0] mreg [15][V];
  int           m_phase;   // 0 idle, 1 collecting lanes, 2 completion cycle
  int           m_tgt;
  int           m_lane;

  task automatic model_clear();
    for (int r = 0; r < 15; r++)
      for (int i = 0; i < V; i++) mreg[r][i] = '0;
    m_phase = 0;
    m_tgt   = 0;
    m_lane  = 0;
  endtask

  function automatic logic [W-1:0] model_vec(input int a);
    logic [W-1:0] v;
    for (int i = 0; i < V; i++) v[i*N +: N] = mreg[a][i];
    return v;
  endfunction

  function automatic logic [W-1:0] exp_rd(input logic [3:0] a, input logic [N-1:0] pc);
    logic [W-1:0] v;
    if (a == 4'd15) begin
      for (int i = 0; i < V; i++) v[i*N +: N] = pc;
    end else begin
      v = model_vec(int'(a));
    end
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear();
    end else begin
      if (bus.WriteEnable && bus.WriteAddr != 4'd15)
        for (int i = 0; i < V; i++)
          if (bus.WriteMask[i]) mreg[bus.WriteAddr][i] = bus.WriteData[i*N +: N];
      case (m_phase)
        0: if (bus.ld_start && bus.ld_addr != 4'd15) begin
             m_phase = 1;
             m_tgt   = int'(bus.ld_addr);
             m_lane  = 0;
           end
        1: if (bus.s_valid) begin
             mreg[m_tgt][m_lane] = bus.s_data;
             if (m_lane == V - 1) m_phase = 2;
             else m_lane++;
           end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd1",     bus.rd1,     exp_rd(bus.ra1, bus.r15));
      check("rd2",     bus.rd2,     exp_rd(bus.ra2, bus.r15));
      check("s_ready", W'(bus.s_ready), W'(m_phase == 1));
      check("ld_busy", W'(bus.ld_busy), W'(m_phase == 1));
      check("ld_done", W'(bus.ld_done), W'(m_phase == 2));
      check("busy",    W'(bus.busy),    (m_phase != 0) ? W'(15'(1) << m_tgt) : '0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.WriteEnable = 1'b0;
    bus.WriteAddr   = '0;
    bus.WriteMask   = '0;
    bus.WriteData   = '0;
    bus.ra1         = '0;
    bus.ra2         = '0;
    bus.r15         = '0;
    bus.ld_start    = 1'b0;
    bus.ld_addr     = '0;
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
  endtask

  localparam logic [W-1:0] PC_VEC  = {18'h00ABC, 18'h00ABC, 18'h00ABC};
  localparam logic [W-1:0] R3_VEC  = {18'h3FFFF, 18'h00000, 18'h00001};
  localparam logic [W-1:0] R7_A    = {18'h00030, 18'h00020, 18'h00010};
  localparam logic [W-1:0] R7_MID  = {18'h2AAAA, 18'h00222, 18'h2AAAA};
  localparam logic [W-1:0] R7_B    = {18'h00333, 18'h00222, 18'h2AAAA};
  localparam logic [W-1:0] R5_PART = {18'h00000, 18'h00000, 18'h00005};
  localparam logic [W-1:0] R9_VEC  = {18'h00003, 18'h00002, 18'h00001};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_clear();
    reset = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    settle();
    check("rst_s_ready", W'(bus.s_ready), '0);
    check("rst_busy",    W'(bus.busy),    '0);
    check("rst_ld_done", W'(bus.ld_done), '0);
    tick();
    reset = 1'b0;

    // All registers read zero after reset.
    for (int a = 0; a < 15; a++) begin
      bus.ra1 = 4'(a);
      bus.ra2 = 4'(14 - a);
      settle();
      check("rst_rd1", bus.rd1, '0);
      tick();
    end

    // PC alias broadcast.
    bus.ra1 = 4'd15;
    bus.r15 = 18'h00ABC;
    settle();
    check("pc_bcast", bus.rd1, PC_VEC);
    tick();

    // Masked write; same-cycle read sees old data.
    bus.WriteEnable = 1'b1;
    bus.WriteAddr   = 4'd3;
    bus.WriteMask   = 3'b101;
    bus.WriteData   = {18'h3FFFF, 18'h11111, 18'h00001};
    bus.ra1         = 4'd3;
    settle();
    check("same_cycle_old", bus.rd1, '0);
    tick();
    bus.WriteEnable = 1'b0;
    settle();
    check("masked_write", bus.rd1, R3_VEC);
    check("model_r3",     model_vec(3), R3_VEC);
    tick();

    // Write to address 15 changes nothing.
    bus.WriteEnable = 1'b1;
    bus.WriteAddr   = 4'd15;
    bus.WriteMask   = 3'b111;
    bus.WriteData   = '1;
    bus.ra2         = 4'd0;
    tick();
    bus.WriteEnable = 1'b0;
    settle();
    check("wr15_r3", bus.rd1, R3_VEC);
    check("wr15_r0", bus.rd2, '0);
    tick();

    // Load reg 7 with a two-cycle stall.
    bus.ld_start = 1'b1;
    bus.ld_addr  = 4'd7;
    tick();
    bus.ld_start = 1'b0;
    bus.s_valid  = 1'b1;
    bus.s_data   = 18'h00010;
    settle();
    check("load_busy",  W'(bus.busy),    W'(15'h0080));
    check("load_ready", W'(bus.s_ready), W'(1'b1));
    tick();
    bus.s_valid = 1'b0;
    tick();
    tick();
    bus.s_valid = 1'b1;
    bus.s_data  = 18'h00020;
    tick();
    bus.s_data  = 18'h00030;
    tick();
    bus.s_valid = 1'b0;
    bus.ra1     = 4'd7;
    settle();
    check("done_pulse", W'(bus.ld_done), W'(1'b1));
    check("done_busy",  W'(bus.busy),    W'(15'h0080));
    check("load_r7",    bus.rd1,         R7_A);
    check("model_r7",   model_vec(7),    R7_A);
    tick();
    settle();
    check("after_done", W'(bus.ld_done), '0);
    check("after_busy", W'(bus.busy),    '0);
    tick();

    // Reload reg 7 with a colliding port-3 write and an ignored ld_start.
    bus.ld_start = 1'b1;
    bus.ld_addr  = 4'd7;
    tick();
    bus.ld_start = 1'b0;
    bus.s_valid  = 1'b1;
    bus.s_data   = 18'h00111;
    tick();
    bus.s_data      = 18'h00222;
    bus.WriteEnable = 1'b1;
    bus.WriteAddr   = 4'd7;
    bus.WriteMask   = 3'b111;
    bus.WriteData   = {18'h2AAAA, 18'h2AAAA, 18'h2AAAA};
    bus.ld_start    = 1'b1;
    bus.ld_addr     = 4'd2;
    tick();
    bus.WriteEnable = 1'b0;
    bus.ld_start    = 1'b0;
    bus.s_valid     = 1'b0;
    bus.ra2         = 4'd2;
    settle();
    check("collide_r7",  bus.rd1,      R7_MID);
    check("ignore_busy", W'(bus.busy), W'(15'h0080));
    check("ignore_r2",   bus.rd2,      '0);
    tick();
    bus.s_valid = 1'b1;
    bus.s_data  = 18'h00333;
    tick();
    bus.s_valid = 1'b0;
    tick();
    settle();
    check("reload_r7", bus.rd1,      R7_B);
    check("model_r7b", model_vec(7), R7_B);
    tick();

    // Start aimed at the PC alias is ignored.
    bus.ld_start = 1'b1;
    bus.ld_addr  = 4'd15;
    tick();
    bus.ld_start = 1'b0;
    settle();
    check("pc_start_ready", W'(bus.s_ready), '0);
    check("pc_start_busy",  W'(bus.busy),    '0);
    tick();

    // Asynchronous reset mid-load.
    bus.ld_start = 1'b1;
    bus.ld_addr  = 4'd5;
    tick();
    bus.ld_start = 1'b0;
    bus.s_valid  = 1'b1;
    bus.s_data   = 18'h00005;
    tick();
    bus.s_valid = 1'b0;
    bus.ra1     = 4'd5;
    bus.ra2     = 4'd7;
    #1;
    check("partial_r5", bus.rd1, R5_PART);
    #1 reset = 1'b1;
    #1;
    check("arst_r5",    bus.rd1,         '0);
    check("arst_r7",    bus.rd2,         '0);
    check("arst_ready", W'(bus.s_ready), '0);
    check("arst_busy",  W'(bus.busy),    '0);
    check("arst_lbusy", W'(bus.ld_busy), '0);
    tick();
    reset = 1'b0;

    // Fresh load after reset.
    bus.ld_start = 1'b1;
    bus.ld_addr  = 4'd9;
    tick();
    bus.ld_start = 1'b0;
    bus.s_valid  = 1'b1;
    for (int i = 1; i <= V; i++) begin
      bus.s_data = 18'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.ra1     = 4'd9;
    settle();
    check("fresh_done", W'(bus.ld_done), W'(1'b1));
    check("fresh_r9",   bus.rd1,         R9_VEC);
    tick();

    // Randomized traffic, compared every cycle by the checker process.
    for (int c = 0; c < 3000; c++) begin
      bus.WriteEnable = 1'($urandom_range(0, 1));
      bus.WriteAddr   = 4'($urandom_range(0, 15));
      bus.WriteMask   = 3'($urandom_range(0, 7));
      bus.WriteData   = {18'($urandom), 18'($urandom), 18'($urandom)};
      bus.ra1         = 4'($urandom_range(0, 15));
      bus.ra2         = 4'($urandom_range(0, 15));
      bus.r15         = 18'($urandom);
      bus.ld_start    = ($urandom_range(0, 5) == 0);
      bus.ld_addr     = 4'($urandom_range(0, 15));
      bus.s_valid     = 1'($urandom_range(0, 1));
      bus.s_data      = 18'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    idle_inputs();
    settle();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_vector_stream.md
Name: regfile_vector_stream

Overview:
Parametrised vector register file: 15 vector registers, each V lanes of N bits. Address 15 reads the r15 input (PC+8) broadcast to all lanes. Adds per-lane masked writes, asynchronous reset of all state, and a lane-serial load engine that fills one destination register one lane per beat over a valid/ready stream. Sits in the vector datapath between decode/operand fetch and the vector ALU/memory writeback.

Parameters:
N, 18, lane width in bits
V, 3, lanes per vector register (V >= 1)
CW, $clog2(V) (min 1), lane counter width (derived, localparam)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
WriteEnable  input  1  port-3 write strobe
WriteAddr  input  4  port-3 destination register
WriteMask  input  V  per-lane write enable; bit i selects lane i
WriteData  input  V*N  write vector; lane i = bits [i*N +: N]
ra1, ra2  input  4  read addresses
r15  input  N  PC+8 value returned for address 15
rd1, rd2  output  V*N  read vectors, same lane packing
ld_start  input  1  start lane-serial load
ld_addr  input  4  load destination register
s_valid  input  1  stream beat valid
s_data  input  N  stream lane data
s_ready  output  1  engine accepts beat
ld_busy  output  1  load in progress
ld_done  output  1  one-cycle pulse, load complete
busy  output  15  per-register pending-load scoreboard

Behaviour:
- Reset (async, active-high): all 15 registers = 0, FSM = IDLE, lane counter = 0, s_ready = 0, ld_busy = 0, ld_done = 0, busy = 0. Reset mid-load aborts it; lanes already written are cleared.
- Reads: combinational. rdX = {V{r15}} when raX == 15, else register[raX]. Write-to-read latency 1 cycle (no bypass); a read in the same cycle as a write returns the old value.
- Port-3 write: on clk edge when WriteEnable, for each lane i with WriteMask[i] = 1, register[WriteAddr] lane i <= WriteData lane i; other lanes unchanged. WriteAddr == 15 ignored. WriteMask == 0 is a no-op.
- Load FSM (one-hot or enum, 3 states):
  IDLE: s_ready = 0. If ld_start and ld_addr != 15 -> LOAD; latch ld_addr, counter = 0, busy[ld_addr] = 1. ld_start with ld_addr == 15 is ignored.
  LOAD: s_ready = 1, ld_busy = 1. On s_valid && s_ready, lane[counter] of the target <= s_data. Counter increments; on the beat with counter == V-1 -> DONE. s_valid low stalls indefinitely, no timeout.
  DONE: ld_done = 1 for exactly one cycle, s_ready = 0, busy[target] cleared at the end of this cycle -> IDLE.
- ld_start outside IDLE is ignored (no queueing). Minimum load time from ld_start to the ld_done edge is V+1 cycles; the next ld_start is accepted in the cycle after DONE.
- Simultaneous port-3 write and stream beat to the same register and lane: the stream beat wins for that lane. Port-3 writes to the other masked lanes still apply.
- A port-3 write to a busy register is allowed; the scoreboard is advisory only. Reads of a busy register return partially updated contents.
- busy: one-hot of the active target during LOAD/DONE, else 0.

Decomposition:
- Package vrf_pkg: LANE_W/LANES defaults, lane_t, vec_t (packed [V-1:0][N-1:0]), addr_t (4-bit), REG_PC = 4'd15, ld_state_t enum {IDLE, LOAD, DONE}.
- Sub-module vrf_stream_ctrl: FSM, lane counter, latched target, s_ready/ld_busy/ld_done/busy generation. It emits a lane-write strobe, lane index and target to the storage array in the top module.

Test Plan (N=18, V=3):
- Reset release -> all rd1/rd2 = 0 for addr 0..14; rd1 with ra1=15, r15=18'h00ABC -> rd1 = {3{18'h00ABC}}; s_ready = ld_busy = ld_done = 0, busy = 0.
- Write addr 3, mask 3'b101, data lanes {2:18'h3FFFF, 1:18'h11111, 0:18'h00001} onto zeros -> next cycle rd1(ra1=3) lanes {18'h3FFFF, 0, 18'h00001}; WriteAddr=15 write -> no register changes.
- ld_start addr 7; beats 18'h00010, stall 2 cycles (s_valid=0), 18'h00020, 18'h00030 -> busy = 15'h0080 during load; ld_done pulses once; reg 7 = {18'h00030, 18'h00020, 18'h00010}; busy = 0 afterwards.
- During load to reg 7 lane 1 beat, port-3 write reg 7, mask 3'b111, all lanes 18'h2AAAA -> lane 1 = stream data; lanes 0 and 2 = 18'h2AAAA.
- Second ld_start (addr 2) during LOAD -> ignored, busy unchanged, reg 2 untouched; ld_start addr 15 in IDLE -> stays IDLE.
- Assert reset asynchronously (mid-cycle) after 1 beat of a load -> outputs and registers 0 immediately, FSM IDLE; a fresh load completes normally after release.
